// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   localparam int MIN_OS_FACTOR = 4;
   localparam int MAX_OS_FACTOR = 16;

   // Turn the raw factor input into a usable one: below the minimum uses
   // the minimum, odd values drop to the even value below so HALF is exact.
   function automatic logic [4:0] legal_factor(input logic [4:0] raw);
      logic [4:0] f;
      f = raw & 5'b11110;
      if (raw < 5'(MIN_OS_FACTOR)) begin
         f = 5'(MIN_OS_FACTOR);
      end
      return f;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw line through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by an oversampling strobe. Detects the start bit,
// samples every bit at its centre using a per-bit tick counter, deserialises
// LSB-first frames and reports good bytes or framing errors as 1-clk pulses.
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 os_tick,
   input  logic [4:0]           oversampling_factor,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 busy
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   logic                 rx_s;
   state_t               state;
   state_t               state_next;
   logic [4:0]           scnt;
   logic [3:0]           bcnt;
   logic [4:0]           f_lat;
   logic [4:0]           f_m1;
   logic [4:0]           half_m1;
   logic [DATA_BITS-1:0] shreg;
   logic                 start_done;
   logic                 bit_take;
   logic                 frame_ok;
   logic                 frame_bad;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .rx  (rx),
      .rx_s(rx_s)
   );

   assign f_m1    = f_lat - 5'd1;
   assign half_m1 = {1'b0, f_lat[4:1]} - 5'd1;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Decode the sampling points of the current state; only a tick can hit one.
   always_comb begin
      start_done = 1'b0;
      bit_take   = 1'b0;
      frame_ok   = 1'b0;
      frame_bad  = 1'b0;
      if (os_tick) begin
         case (state)
            START: start_done = (scnt == half_m1);
            DATA:  bit_take   = (scnt == f_m1);
            STOP: begin
               if (scnt == f_m1) begin
                  frame_ok  = rx_s;
                  frame_bad = ~rx_s;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state logic; a glitchy start returns to IDLE, a low stop bit
   // parks in BREAK until the line goes high again.
   always_comb begin
      state_next = state;
      if (os_tick) begin
         case (state)
            IDLE:  if (!rx_s) state_next = START;
            START: if (start_done) state_next = rx_s ? IDLE : DATA;
            DATA:  if (bit_take && (bcnt == LAST_BIT)) state_next = STOP;
            STOP: begin
               if (frame_ok) state_next = IDLE;
               else if (frame_bad) state_next = BREAK;
            end
            BREAK: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Tick counters, latched factor and the shift register; all hold
   // between ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         scnt  <= '0;
         bcnt  <= '0;
         f_lat <= '0;
         shreg <= '0;
      end else if (os_tick) begin
         case (state)
            IDLE: begin
               scnt <= '0;
               if (!rx_s) begin
                  f_lat <= legal_factor(oversampling_factor);
               end
            end
            START: begin
               if (start_done) begin
                  scnt <= '0;
                  bcnt <= '0;
               end else begin
                  scnt <= scnt + 5'd1;
               end
            end
            DATA: begin
               if (bit_take) begin
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  scnt  <= '0;
                  bcnt  <= bcnt + 4'd1;
               end else begin
                  scnt <= scnt + 5'd1;
               end
            end
            STOP: begin
               if (scnt == f_m1) begin
                  scnt <= '0;
               end else begin
                  scnt <= scnt + 5'd1;
               end
            end
            default: scnt <= '0;
         endcase
      end
   end

   // Registered outputs: result pulses appear the clock after the stop-bit
   // sample, and busy tracks the state being entered so it equals state!=IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         framing_error <= 1'b0;
         busy          <= 1'b0;
      end else begin
         rx_valid      <= frame_ok;
         framing_error <= frame_bad;
         busy          <= (state_next != IDLE);
         if (frame_ok) begin
            rx_data <= shreg;
         end
      end
   end

endmodule
